// File: rtl/stereo_smpl_queue.sv
// stereo_smpl_queue: circular stereo sample buffer feeding the FIR stage with
// TAPS-long bursts of the newest samples, oldest first.
module stereo_smpl_queue #(
    parameter int DEPTH = 1024,
    parameter int TAPS  = 1021
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt_smpl,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    output logic               sequencing,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);
    typedef logic [PW:0] ext_t;
    localparam ext_t DEPTH_E    = ext_t'(DEPTH);
    localparam ext_t LAUNCH_OFS = ext_t'(DEPTH + 1 - TAPS);
    localparam ext_t PEND_OFS   = ext_t'(DEPTH - TAPS);
    localparam logic [CW-1:0] TAPS_C = CW'(TAPS);
    localparam logic [CW-1:0] LAST_C = CW'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       fill_cnt_q, fill_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                pend_q, pend_d, full_q, full_d, seq_q, seq_d, launch;
    logic signed [15:0]  lft_out_q, rght_out_q;
    logic [31:0]         mem [DEPTH];

    // Modulo-DEPTH add with one explicit wrap; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] add_mod(input logic [PW-1:0] a, input ext_t b);
        ext_t s;
        s = {1'b0, a} + b;
        return (s >= DEPTH_E) ? PW'(s - DEPTH_E) : PW'(s);
    endfunction

    always_comb begin
        fill_cnt_d = (wrt_smpl && fill_cnt_q != TAPS_C) ? fill_cnt_q + CW'(1) : fill_cnt_q;
        full_d     = fill_cnt_d == TAPS_C;
        launch     = wrt_smpl && full_d;
        wr_ptr_d   = wrt_smpl ? add_mod(wr_ptr_q, ext_t'(1)) : wr_ptr_q;
        seq_d      = state_q == READ;
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        pend_d     = pend_q;
        case (state_q)
            IDLE: if (launch) begin
                state_d  = READ;
                rd_ptr_d = add_mod(wr_ptr_q, LAUNCH_OFS);
                rd_cnt_d = '0;
            end
            READ: begin
                rd_ptr_d = add_mod(rd_ptr_q, ext_t'(1));
                rd_cnt_d = rd_cnt_q + CW'(1);
                pend_d   = pend_q | wrt_smpl;
                state_d  = (rd_cnt_q == LAST_C) ? GAP : READ;
            end
            GAP: begin
                // A write landing in the gap folds into the pending burst so it is never lost.
                pend_d = 1'b0;
                if (pend_q || launch) begin
                    state_d  = READ;
                    rd_ptr_d = add_mod(wr_ptr_d, PEND_OFS);
                    rd_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wrt_smpl) mem[wr_ptr_q] <= {lft_smpl, rght_smpl};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_cnt_q <= '0;
            rd_cnt_q   <= '0;
            pend_q     <= 1'b0;
            full_q     <= 1'b0;
            seq_q      <= 1'b0;
            lft_out_q  <= '0;
            rght_out_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pend_q     <= pend_d;
            full_q     <= full_d;
            seq_q      <= seq_d;
            if (seq_d) {lft_out_q, rght_out_q} <= mem[rd_ptr_q];
        end
    end

    assign sequencing = seq_q;
    assign full       = full_q;
    assign lft_out    = lft_out_q;
    assign rght_out   = rght_out_q;
endmodule
